// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and fetch sequencer (IDLE/RUN/HALTED)
// in front of a combinational instruction memory.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   start            pulse: begin execution at START_PC
//   halt             halt instruction at current pc
//   stall            hold pc this cycle
//   branch_en        taken branch at current pc
//   branch_rel       1 = pc + signed LUT entry, 0 = absolute entry
//   branch_idx       branch-target LUT read index
//   lut_we/waddr/wdata  branch-target LUT write port
//   call_en, ret_en  (LINK_REG_EN only) call / return via link register
//   pc               fetch address
//   running, done    state == RUN, state == HALTED
//
// Optional feature macro: LINK_REG_EN (one-level link register).
module pc_fetch_unit #(
  parameter int unsigned      PC_W      = 8,
  parameter int unsigned      LUT_IDX_W = 4,
  parameter logic [PC_W-1:0]  START_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 halt,
  input  logic                 stall,
  input  logic                 branch_en,
  input  logic                 branch_rel,
  input  logic [LUT_IDX_W-1:0] branch_idx,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]      lut_wdata,
`ifdef LINK_REG_EN
  input  logic                 call_en,
  input  logic                 ret_en,
`endif
  output logic [PC_W-1:0]      pc,
  output logic                 running,
  output logic                 done
);

  localparam int LUT_N = 1 << LUT_IDX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED
  } state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_running;
  logic            r_done;
  logic [PC_W-1:0] r_lut [LUT_N];

  logic [PC_W-1:0] w_lut_rd;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_rel;
  logic [PC_W-1:0] w_run_pc;

`ifdef LINK_REG_EN
  logic [PC_W-1:0] r_link;
`endif

  // Old LUT contents are read here; the write lands on the edge,
  // so a same-cycle branch sees the previous entry.
  assign w_lut_rd = r_lut[branch_idx];
  assign w_pc_inc = r_pc + PC_W'(1);
  // Same-width add wraps mod 2**PC_W, which equals adding the
  // sign-extended entry.
  assign w_pc_rel = r_pc + w_lut_rd;

  // Next pc while running and not halting.
  always_comb begin
    w_run_pc = w_pc_inc;
    if (stall) begin
      w_run_pc = r_pc;
`ifdef LINK_REG_EN
    end else if (ret_en) begin
      w_run_pc = r_link;
    end else if (call_en) begin
      w_run_pc = w_lut_rd;
`endif
    end else if (branch_en) begin
      w_run_pc = branch_rel ? w_pc_rel : w_lut_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pc      <= START_PC;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_RUN;
            r_pc      <= START_PC;
            r_running <= 1'b1;
          end
        end
        S_RUN: begin
          if (halt) begin
            r_state   <= S_HALTED;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_pc <= w_run_pc;
          end
        end
        S_HALTED: begin
          if (start) begin
            r_state   <= S_RUN;
            r_pc      <= START_PC;
            r_running <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_pc      <= START_PC;
          r_running <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LUT_N; i++) begin
        r_lut[i] <= '0;
      end
    end else if (lut_we) begin
      r_lut[lut_waddr] <= lut_wdata;
    end
  end

`ifdef LINK_REG_EN
  // Link captured only when the call actually wins arbitration.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_link <= '0;
    end else if (r_state == S_RUN && !halt && !stall
                 && !ret_en && call_en) begin
      r_link <= w_pc_inc;
    end
  end
`endif

  assign pc      = r_pc;
  assign running = r_running;
  assign done    = r_done;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed + random stimulus for pc_fetch_unit,
// checked every cycle against a behavioural model.
module tb_pc_fetch_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       halt = 1'b0;
  logic       stall = 1'b0;
  logic       branch_en = 1'b0;
  logic       branch_rel = 1'b0;
  logic [3:0] branch_idx = '0;
  logic       lut_we = 1'b0;
  logic [3:0] lut_waddr = '0;
  logic [7:0] lut_wdata = '0;
`ifdef LINK_REG_EN
  logic       call_en = 1'b0;
  logic       ret_en = 1'b0;
`endif
  logic [7:0] pc;
  logic       running;
  logic       done;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  // model: 0 idle, 1 run, 2 halted
  int m_st = 0;
  int m_pc = 0;
  int m_lut [16];

  pc_fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .halt       (halt),
    .stall      (stall),
    .branch_en  (branch_en),
    .branch_rel (branch_rel),
    .branch_idx (branch_idx),
    .lut_we     (lut_we),
    .lut_waddr  (lut_waddr),
    .lut_wdata  (lut_wdata),
`ifdef LINK_REG_EN
    .call_en    (call_en),
    .ret_en     (ret_en),
`endif
    .pc         (pc),
    .running    (running),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic int sx8(int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  always @(posedge clk) begin
    int rd;
    if (reset) begin
      m_st = 0;
      m_pc = 0;
      foreach (m_lut[i]) m_lut[i] = 0;
    end else begin
      rd = m_lut[branch_idx];
      if (m_st == 0) begin
        if (start) begin m_st = 1; m_pc = 0; end
      end else if (m_st == 1) begin
        if (halt) m_st = 2;
        else if (stall) m_pc = m_pc;
        else if (branch_en && branch_rel)
          m_pc = ((m_pc + sx8(rd)) % 256 + 256) % 256;
        else if (branch_en) m_pc = rd;
        else m_pc = (m_pc + 1) % 256;
      end else begin
        if (start) begin m_st = 1; m_pc = 0; end
      end
      if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
    end
  end

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", int'(pc), m_pc);
      chk("running", int'(running), int'(m_st == 1));
      chk("done", int'(done), int'(m_st == 2));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr(int idx, int data);
    lut_we = 1'b1;
    lut_waddr = 4'(idx);
    lut_wdata = 8'(data);
    cyc();
    lut_we = 1'b0;
  endtask

  task automatic br(int idx, bit rel);
    branch_en = 1'b1;
    branch_rel = rel;
    branch_idx = 4'(idx);
    cyc();
    branch_en = 1'b0;
    branch_rel = 1'b0;
  endtask

  initial begin
    cyc();
    cyc();
    reset = 1'b0;
    chk_en = 1;
    chk("rst_pc", int'(pc), 0);
    chk("rst_run", int'(running), 0);
    chk("rst_done", int'(done), 0);

    start = 1'b1; cyc(); start = 1'b0;
    chk("start_pc0", int'(pc), 0);
    chk("start_run", int'(running), 1);
    cyc(); chk("seq1", int'(pc), 1);
    cyc(); chk("seq2", int'(pc), 2);
    cyc(); chk("seq3", int'(pc), 3);

    wr(1, 8'hFE);
    br(1, 0); chk("wrap_fe", int'(pc), 8'hFE);
    cyc(); chk("wrap_ff", int'(pc), 8'hFF);
    cyc(); chk("wrap_00", int'(pc), 0);
    cyc(); chk("wrap_01", int'(pc), 1);
    chk("wrap_run", int'(running), 1);

    wr(2, 8'h10);
    wr(3, 8'h40);
    br(2, 0); chk("abs_10", int'(pc), 8'h10);
    br(3, 0); chk("abs_40", int'(pc), 8'h40);
    cyc(); chk("abs_41", int'(pc), 8'h41);

    wr(4, 8'h02);
    wr(5, 8'hFC);
    br(4, 0); chk("rel_02", int'(pc), 8'h02);
    br(5, 1); chk("rel_fe", int'(pc), 8'hFE);
    wr(6, 8'h05);
    wr(7, 8'hFD);
    br(7, 0); chk("rel_fd", int'(pc), 8'hFD);
    br(6, 1); chk("rel_wrap", int'(pc), 8'h02);

    wr(8, 8'h20);
    br(8, 0); chk("hb_20", int'(pc), 8'h20);
    halt = 1'b1; branch_en = 1'b1; branch_idx = 4'd3;
    cyc();
    halt = 1'b0; branch_en = 1'b0;
    chk("hb_pc", int'(pc), 8'h20);
    chk("hb_done", int'(done), 1);
    chk("hb_run", int'(running), 0);
    halt = 1'b1; stall = 1'b1; branch_en = 1'b1;
    cyc();
    halt = 1'b0; stall = 1'b0; branch_en = 1'b0;
    chk("hlt_hold", int'(pc), 8'h20);
    start = 1'b1; cyc(); start = 1'b0;
    chk("restart_pc", int'(pc), 0);
    chk("restart_done", int'(done), 0);

    lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 8'h80;
    br(3, 0);
    lut_we = 1'b0;
    chk("rbw_old", int'(pc), 8'h40);
    br(3, 0); chk("rbw_new", int'(pc), 8'h80);

    wr(9, 8'h07);
    br(9, 0); chk("stall_07", int'(pc), 8'h07);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("stall_hold", int'(pc), 8'h07);
    end
    stall = 1'b0;
    cyc(); chk("stall_rel", int'(pc), 8'h08);

    wr(10, 8'h30);
    br(10, 0); chk("mr_30", int'(pc), 8'h30);
    reset = 1'b1; branch_en = 1'b1; branch_idx = 4'd3;
    lut_we = 1'b1; lut_waddr = 4'd4; lut_wdata = 8'h55;
    cyc();
    reset = 1'b0; branch_en = 1'b0; lut_we = 1'b0;
    chk("mr_pc", int'(pc), 0);
    chk("mr_run", int'(running), 0);
    cyc(); chk("mr_idle_hold", int'(pc), 0);
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); chk("mr_pc1", int'(pc), 1);
    br(3, 0); chk("mr_lut3", int'(pc), 0);
    cyc();
    br(4, 0); chk("mr_lut4", int'(pc), 0);

    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom % 200) == 0;
      start      = ($urandom % 10) == 0;
      halt       = ($urandom % 25) == 0;
      stall      = ($urandom % 6) == 0;
      branch_en  = ($urandom % 5) == 0;
      branch_rel = 1'($urandom);
      branch_idx = 4'($urandom);
      lut_we     = ($urandom % 4) == 0;
      lut_waddr  = 4'($urandom);
      lut_wdata  = 8'($urandom);
      cyc();
    end
    reset = 1'b0; start = 1'b0; halt = 1'b0; stall = 1'b0;
    branch_en = 1'b0; lut_we = 1'b0;
    cyc();
    chk_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and fetch-sequencing stage directly upstream of the 256-entry, 9-bit-wide combinational instruction memory.
- Drives the 8-bit fetch address.
- Sequences execution through start, run and halt.
- Resolves taken branches through a writable branch-target lookup table (LUT), in absolute or PC-relative mode.

Parameters:
PC_W, 8, program counter width; instruction memory depth is 2**PC_W
LUT_IDX_W, 4, branch-target LUT index width (16 entries)
START_PC, 0, PC loaded on start

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  pulse; begins execution at START_PC
halt  input  1  decoder flags a halt instruction at the current pc
stall  input  1  hold pc this cycle
branch_en  input  1  taken branch at the current pc
branch_rel  input  1  1 = relative (pc + signed entry), 0 = absolute entry
branch_idx  input  LUT_IDX_W  LUT entry selecting target/offset
lut_we  input  1  LUT write enable
lut_waddr  input  LUT_IDX_W  LUT write index
lut_wdata  input  PC_W  LUT write data
pc  output  PC_W  fetch address to instruction memory
running  output  1  state == RUN
done  output  1  state == HALTED

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high, sampled on the rising edge of clk.
- States: IDLE, RUN, HALTED; encoding is free.
- Reset:
  - state=IDLE, pc=START_PC, running=0, done=0.
  - All LUT entries cleared to 0.
  - Reset asserted mid-RUN aborts on that edge; no pending branch or LUT write takes effect.
- IDLE:
  - start -> RUN, pc=START_PC.
  - All other control inputs ignored; pc holds.
- RUN, per-edge priority: halt > stall > branch_en > increment.
  - halt: -> HALTED; pc holds (the halting instruction's address stays visible).
  - stall: pc holds.
  - branch_en && !branch_rel: pc = LUT[branch_idx].
  - branch_en && branch_rel: pc = pc + sign_extend(LUT[branch_idx]), modulo 2**PC_W.
  - Otherwise: pc = pc + 1, modulo 2**PC_W (255 -> 0).
  - start during RUN is ignored.
- HALTED:
  - pc holds; done=1.
  - start -> RUN with pc=START_PC; done drops on that same edge.
  - halt, stall and branch_en are ignored.
- Latency:
  - pc changes one edge after the causing inputs.
  - Instruction memory is combinational, so the instruction at the new pc is valid in the cycle after the edge.
- LUT writes:
  - Accepted in every state except the reset cycle.
  - Written on the clock edge.
  - A same-cycle branch read of the index being written uses the OLD value (read-before-write).
- Outputs are registered or decoded from registered state only; no combinational path from any input to pc, running or done.
- halt && branch_en in the same cycle: halt wins, and no branch is taken.

Optional Feature:
LINK_REG_EN
- Defined:
  - Adds inputs call_en and ret_en and an internal PC_W-bit link register, reset to 0.
  - In RUN, call_en has the same priority as branch_en and is mutually exclusive with it; if both are asserted, call_en wins.
  - call_en: link = pc + 1 (mod 2**PC_W); pc = LUT[branch_idx], always absolute.
  - ret_en: pc = link; priority is below stall and above call_en.
  - One-level only; a nested call overwrites link.
- Undefined: no call_en/ret_en ports, no link register; behaviour is exactly as above.

Test Plan:
- Reset then start: reset 1 cycle, start pulse -> pc sequence 0,1,2,3; running=1; done=0.
- Wrap-around: run free from pc=254 -> 255, then 0, then 1; no state change.
- Absolute branch: LUT[3]=0x40 written, branch_en=1, branch_rel=0, branch_idx=3 at pc=0x10 -> next pc=0x40, then 0x41.
- Relative branch with wrap: LUT[5]=0xFC (-4), branch_rel=1 at pc=0x02 -> next pc=0xFE; with LUT[6]=0x05 at pc=0xFD -> next pc=0x02.
- Priority and same-cycle write:
  - halt+branch_en at pc=0x20 -> pc stays 0x20, done=1, running=0.
  - Then start -> pc=0, done=0.
  - Separately: lut_we to index 3 (data 0x80) in the same cycle as a branch via index 3 (old 0x40) -> pc=0x40; LUT[3] reads 0x80 afterwards.
- Stall and mid-run reset:
  - stall held 3 cycles at pc=0x07 -> pc stays 0x07, then 0x08 when released.
  - reset asserted at pc=0x30 -> IDLE, pc=0, LUT entries 0.
